// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename busy/tag table
module rename_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int TAG_W  = 4,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rdy_i,
    input  logic                  flush_i,
    input  logic [NRP*AW-1:0]     rd_addr_i,
    output logic [NRP-1:0]        rd_ready_o,
    output logic [NRP*XLEN-1:0]   rd_val_o,
    input  logic                  rn_en_i,
    input  logic [AW-1:0]         rn_addr_i,
    input  logic [TAG_W-1:0]      rn_tag_i,
    input  logic                  cm_en_i,
    input  logic [AW-1:0]         cm_addr_i,
    input  logic [XLEN-1:0]       cm_val_i,
    input  logic [TAG_W-1:0]      cm_tag_i,
    output logic [AW:0]           busy_cnt_o
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic cm_we, rn_we, cm_clr, rn_set;

    always_comb begin
        cm_we  = cm_en_i && (cm_addr_i != '0);
        rn_we  = rn_en_i && (rn_addr_i != '0) && !flush_i;
        // A same-cycle rename of the committed register keeps it busy under the new tag.
        cm_clr = cm_we && busy_q[cm_addr_i] && (tag_q[cm_addr_i] == cm_tag_i)
                 && !(rn_we && (rn_addr_i == cm_addr_i));
        rn_set = rn_we && !busy_q[rn_addr_i];

        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (cm_clr) busy_d[cm_addr_i] = 1'b0;
            if (rn_we)  busy_d[rn_addr_i] = 1'b1;
        end

        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (rn_set && !cm_clr) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cm_clr && !rn_set) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_i) begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (cm_we) val_q[cm_addr_i] <= cm_val_i;
            if (rn_we) tag_q[rn_addr_i] <= rn_tag_i;
        end
    end

    assign busy_cnt_o = cnt_q;

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] tag_ext;
        rd_ready_o = '0;
        rd_val_o   = '0;
        for (int p = 0; p < NRP; p++) begin
            a       = rd_addr_i[p*AW +: AW];
            tag_ext = '0;
            tag_ext[TAG_W-1:0] = tag_q[a];
            if (a == '0) begin
                rd_ready_o[p]          = 1'b1;
                rd_val_o[p*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && rdy_i && cm_en_i && (cm_addr_i == a) && busy_q[a]
                         && (tag_q[a] == cm_tag_i) && !(rn_en_i && (rn_addr_i == a))) begin
                rd_ready_o[p]          = 1'b1;
                rd_val_o[p*XLEN +: XLEN] = cm_val_i;
            end else if (busy_q[a]) begin
                rd_ready_o[p]          = 1'b0;
                rd_val_o[p*XLEN +: XLEN] = tag_ext;
            end else begin
                rd_ready_o[p]          = 1'b1;
                rd_val_o[p*XLEN +: XLEN] = val_q[a];
            end
        end
    end

endmodule
